uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmit frame engine for the front-end serial path. Accepts a DATA_W-bit parallel word on a valid strobe, computes the selected parity at load time, and serialises start, data (LSB first), optional parity and one or two stop bits at one bit per clk cycle. It replaces the fixed 8-bit even/odd parity generator plus separate serializer with one block. Data width and parity mode are configurable.

## Interface
- DATA_W, 8, data bits per frame (5..9)
- clk  input  1  bit clock; one serial bit per rising edge
- RST_n  input  1  reset, asynchronous, active-low
- P_DATA  input  DATA_W  parallel data to send
- Data_Valid  input  1  request; sampled only in IDLE
- PAR_EN  input  1  1 inserts parity bit
- PAR_TYP  input  2  00 even, 01 odd, 10 mark (1), 11 space (0)
- STOP2  input  1  1 selects two stop bits
- OVR_CLR  input  1  clears OVR
- TX_OUT  output  1  serial line, idle high
- Busy  output  1  frame in progress
- OVR  output  1  sticky overrun flag

## Operation
- Reset values: state IDLE, TX_OUT=1, Busy=0, OVR=0, shift register and bit counter 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1. Data_Valid=1 latches P_DATA, PAR_EN, PAR_TYP and STOP2. Parity bit is computed from the latched data and registered. Next state START.
- Parity: even = ^P_DATA; odd = ~^P_DATA; mark = 1; space = 0.
- START: TX_OUT=0 for one cycle, then DATA.
- DATA: TX_OUT = shift[0], shift right each cycle, for DATA_W cycles (counter 0..DATA_W-1). Then PARITY if PAR_EN, else STOP.
- PARITY: TX_OUT = registered parity bit for one cycle, then STOP.
- STOP: TX_OUT=1 for 1 cycle, or 2 cycles when latched STOP2=1, then IDLE.
- Inputs are ignored after the load edge; config changes mid-frame do not affect the current frame.
- Busy=1 in every state except IDLE.
- Data_Valid while Busy=1 is ignored (no queueing).
- Frame length = 1 + DATA_W + PAR_EN + 1 + STOP2 cycles.

## Timing
- Load edge N (IDLE, Data_Valid=1) sets Busy=1 and TX_OUT=0 (start bit) from edge N onward. TX_OUT is registered.
- Data bit k is driven from edge N+1+k.
- Busy falls on the edge that enters IDLE, i.e. edge N+frame length.
- A Data_Valid held high from that edge loads on the next edge, so there is at least one idle-high cycle between frames.
- Reset mid-frame: outputs return immediately to reset values; the partial frame is abandoned.
- OVR_CLR and a new overrun in the same cycle: set wins.

## Configuration
- UART_TX_OVR_EN defined: OVR sets to 1 on any cycle with Data_Valid=1 and Busy=1. It holds until OVR_CLR=1 (cleared next edge).
- UART_TX_OVR_EN undefined: OVR is constant 0, the OVR_CLR input is unused, and no flag register is synthesised.

## Structure
- Shared package uart_pkg holds:
  - the PAR_TYP encodings (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE);
  - the FSM state enum;
  - DATA_W legal bounds.
- One sub-module, uart_tx_par_gen: combinational parity from data plus PAR_TYP, instantiated at the load path.
- The FSM, shift register, counters and OVR logic stay in uart_tx_frame.

## Test plan
- DATA_W=8, P_DATA=0xA5, PAR_EN=1, even, STOP2=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles. Busy high for exactly 11 cycles.
- Same word, odd -> parity bit 1. Mark -> parity bit 1. Space -> parity bit 0. PAR_EN=0 -> 10-cycle frame with no parity slot.
- DATA_W=7, P_DATA=0x7F, PAR_EN=1, odd, STOP2=1 -> 0, seven 1s, parity 0, 1, 1 (11 cycles).
- Data_Valid held high continuously with 0x3C -> consecutive frames, each separated by exactly one idle-high cycle. P_DATA changed mid-frame does not alter the current frame.
- With UART_TX_OVR_EN, pulse Data_Valid during the DATA state -> OVR=1 next edge, frame unaffected. OVR_CLR pulse -> OVR=0. Without the macro, OVR stays 0.
- Assert RST_n=0 during the DATA state -> TX_OUT=1 and Busy=0 immediately. After release, a new frame with 0x81 transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings, FSM states and width bounds for the UART transmit path
package uart_pkg;

  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;
  // One counter serves both the data-bit index and the stop-bit index.
  localparam int CNT_W = $clog2(DATA_W_MAX);

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_typ_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_par_gen.sv
// rtl/uart_tx_par_gen.sv - combinational parity bit from a data word and parity type
module uart_tx_par_gen
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        par_typ_i,
  output logic              par_o
);

  // Select the parity bit for the requested mode.
  always_comb begin
    par_o = 1'b0;
    case (par_typ_e'(par_typ_i))
      PAR_EVEN:  par_o = ^data_i;
      PAR_ODD:   par_o = ~^data_i;
      PAR_MARK:  par_o = 1'b1;
      PAR_SPACE: par_o = 1'b0;
      default:   par_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit frame engine; optional overrun flag under UART_TX_OVR_EN
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              RST_n,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              Data_Valid,
  input  logic              PAR_EN,
  input  logic [1:0]        PAR_TYP,
  input  logic              STOP2,
  input  logic              OVR_CLR,
  output logic              TX_OUT,
  output logic              Busy,
  output logic              OVR
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              par_en_q, par_en_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              par_bit;

  uart_tx_par_gen #(.DATA_W(DATA_W)) u_par_gen (
    .data_i    (P_DATA),
    .par_typ_i (PAR_TYP),
    .par_o     (par_bit)
  );

  // Next state plus the line level for the state being entered, so TX_OUT is registered.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    stop2_d  = stop2_q;
    tx_d     = 1'b1;
    case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          shift_d  = P_DATA;
          par_d    = par_bit;
          par_en_d = PAR_EN;
          stop2_d  = STOP2;
          cnt_d    = '0;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end
      START: begin
        state_d = DATA;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            state_d = STOP;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      PARITY: begin
        state_d = STOP;
        cnt_d   = '0;
      end
      STOP: begin
        if (stop2_q && cnt_q == '0) begin
          cnt_d = 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame state registers; reset abandons any partial frame.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = (state_q != IDLE);

`ifdef UART_TX_OVR_EN
  logic ovr_q, ovr_d;

  // Sticky overrun: a request while busy sets it, and set beats clear.
  always_comb begin
    ovr_d = ovr_q;
    if (Data_Valid && Busy) begin
      ovr_d = 1'b1;
    end else if (OVR_CLR) begin
      ovr_d = 1'b0;
    end
  end

  // Overrun flag register.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign OVR = ovr_q;
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = OVR_CLR;
  assign OVR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame at DATA_W 8 and 7
module tb_uart_tx_frame;

  typedef bit bitq_t[$];

  logic       clk = 1'b0;
  logic       RST_n;
  logic [1:0] dv, pen, s2, clr;
  logic [8:0] pd  [2];
  logic [1:0] typ [2];
  logic [1:0] tx, busy, ovr;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_W(8)) dut8 (
    .clk(clk), .RST_n(RST_n), .P_DATA(pd[0][7:0]), .Data_Valid(dv[0]), .PAR_EN(pen[0]),
    .PAR_TYP(typ[0]), .STOP2(s2[0]), .OVR_CLR(clr[0]),
    .TX_OUT(tx[0]), .Busy(busy[0]), .OVR(ovr[0])
  );

  uart_tx_frame #(.DATA_W(7)) dut7 (
    .clk(clk), .RST_n(RST_n), .P_DATA(pd[1][6:0]), .Data_Valid(dv[1]), .PAR_EN(pen[1]),
    .PAR_TYP(typ[1]), .STOP2(s2[1]), .OVR_CLR(clr[1]),
    .TX_OUT(tx[1]), .Busy(busy[1]), .OVR(ovr[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Whole frame as a bit list: start, data LSB first, optional parity, stop bit(s).
  function automatic bitq_t build_frame(input int w, input logic [8:0] d, input logic pe,
                                        input logic [1:0] ty, input logic st2);
    bitq_t f;
    int ones = 0;
    f.push_back(1'b0);
    for (int k = 0; k < w; k++) begin
      f.push_back(d[k]);
      if (d[k]) ones++;
    end
    if (pe) begin
      case (ty)
        2'd0:    f.push_back(bit'(ones % 2 == 1));
        2'd1:    f.push_back(bit'(ones % 2 == 0));
        2'd2:    f.push_back(1'b1);
        default: f.push_back(1'b0);
      endcase
    end
    f.push_back(1'b1);
    if (st2) f.push_back(1'b1);
    return f;
  endfunction

  // Reference model: line level, busy and overrun expected after each edge.
  bitq_t      mq [2];
  logic [1:0] m_tx, m_busy, m_ovr;
  int         widths [2] = '{8, 7};

  initial begin
    logic wb;
    m_tx = 2'b11; m_busy = 2'b00; m_ovr = 2'b00;
    forever begin
      @(posedge clk or negedge RST_n);
      if (!RST_n) begin
        for (int i = 0; i < 2; i++) mq[i].delete();
        m_tx = 2'b11; m_busy = 2'b00; m_ovr = 2'b00;
      end else begin
        for (int i = 0; i < 2; i++) begin
          wb = m_busy[i];
          if (mq[i].size() > 0) begin
            m_tx[i] = mq[i].pop_front();
            m_busy[i] = 1'b1;
          end else if (m_busy[i]) begin
            m_tx[i] = 1'b1;
            m_busy[i] = 1'b0;
          end else if (dv[i]) begin
            mq[i] = build_frame(widths[i], pd[i], pen[i], typ[i], s2[i]);
            m_tx[i] = mq[i].pop_front();
            m_busy[i] = 1'b1;
          end
`ifdef UART_TX_OVR_EN
          if (dv[i] && wb) m_ovr[i] = 1'b1;
          else if (clr[i]) m_ovr[i] = 1'b0;
`endif
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("tx[%0d]", i), tx[i], m_tx[i]);
        chk($sformatf("busy[%0d]", i), busy[i], m_busy[i]);
        chk($sformatf("ovr[%0d]", i), ovr[i], m_ovr[i]);
      end
    end
  end

  logic [21:0] rec;
  logic [21:0] txr;
  int          nb;

  task automatic send(input int i, input logic [8:0] d, input logic pe, input logic [1:0] ty,
                      input logic st2, input int pulse_at);
    @(negedge clk);
    pd[i] = d; pen[i] = pe; typ[i] = ty; s2[i] = st2; dv[i] = 1'b1;
    @(negedge clk);
    dv[i] = 1'b0;
    rec = '0;
    nb = 0;
    while (busy[i] && nb < 20) begin
      rec[nb] = tx[i];
      nb++;
      dv[i] = (nb == pulse_at);
      @(negedge clk);
    end
    dv[i] = 1'b0;
    chk("frame_done", nb < 20, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST_n = 1'b0;
    dv = '0; pen = '0; s2 = '0; clr = '0;
    pd[0] = '0; pd[1] = '0; typ[0] = '0; typ[1] = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 2'b11);
    chk("reset_busy", busy, 2'b00);
    chk("reset_ovr", ovr, 2'b00);
    RST_n = 1'b1;

    send(0, 9'h0A5, 1'b1, 2'd0, 1'b0, -1);
    chk("a5_even_bits", rec[10:0], 11'b10101001010);
    chk("a5_even_len", nb, 11);
    send(0, 9'h0A5, 1'b1, 2'd1, 1'b0, -1);
    chk("a5_odd_par", rec[9], 1'b1);
    send(0, 9'h0A5, 1'b1, 2'd2, 1'b0, -1);
    chk("a5_mark_par", rec[9], 1'b1);
    send(0, 9'h0A5, 1'b1, 2'd3, 1'b0, -1);
    chk("a5_space_par", rec[9], 1'b0);
    send(0, 9'h0A5, 1'b0, 2'd0, 1'b0, -1);
    chk("a5_nopar_len", nb, 10);
    chk("a5_nopar_bits", rec[9:0], 10'b1101001010);

    send(1, 9'h07F, 1'b1, 2'd1, 1'b1, -1);
    chk("w7_7f_bits", rec[10:0], 11'b11011111110);
    chk("w7_7f_len", nb, 11);

    @(negedge clk);
    pd[0] = 9'h03C; pen[0] = 1'b0; typ[0] = 2'd0; s2[0] = 1'b0; dv[0] = 1'b1;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      rec[k] = busy[0];
      txr[k] = tx[0];
      if (k == 3) pd[0] = 9'h0FF;
      if (k == 8) pd[0] = 9'h03C;
    end
    dv[0] = 1'b0;
    chk("b2b_busy", rec, 22'h1FFBFF);
    chk("b2b_frame1", txr[9:0], 10'b1001111000);
    chk("b2b_gap", txr[10], 1'b1);
    chk("b2b_frame2", txr[20:11], 10'b1001111000);
    repeat (2) @(negedge clk);

    send(0, 9'h05A, 1'b1, 2'd0, 1'b0, 3);
    chk("ovr_frame", rec[10:0], 11'b10010110100);
`ifdef UART_TX_OVR_EN
    chk("ovr_set", ovr[0], 1'b1);
`else
    chk("ovr_set", ovr[0], 1'b0);
`endif
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("ovr_clr", ovr[0], 1'b0);

    @(negedge clk);
    pd[0] = 9'h0A5; pen[0] = 1'b1; typ[0] = 2'd0; s2[0] = 1'b0; dv[0] = 1'b1;
    @(negedge clk);
    dv[0] = 1'b0;
    repeat (3) @(negedge clk);
    RST_n = 1'b0;
    #1;
    chk("rst_mid_tx", tx, 2'b11);
    chk("rst_mid_busy", busy, 2'b00);
    @(negedge clk);
    RST_n = 1'b1;
    send(0, 9'h081, 1'b1, 2'd0, 1'b0, -1);
    chk("post_rst_81", rec[10:0], 11'b10100000010);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
